vga_sync_rx: RTL and testbench

- Receive side of the team's 640x480 VGA link: samples an incoming hsync/vsync/3-bit RGB stream at pixel rate and recovers horizontal and vertical position.
- Checks that the stream matches the expected 800x525 timing and reports lock or error.
- Emits active-area pixels with x/y coordinates for capture or self-check logic downstream of the VGA generator.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_sync_rx_if.sv | 29 ++
 rtl/vga_rx_axis_cnt.sv | 45 ++++
 rtl/vga_sync_rx.sv | 151 +++++++++++++++
 tb/tb_vga_sync_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480 timing constants shared by the VGA generator and receiver, plus the
// receiver lock-state encoding.
package vga_timing_pkg;

  localparam int unsigned CW          = 10;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned HDAT_BEGIN  = 143;
  localparam int unsigned HDAT_END    = 783;
  localparam int unsigned VDAT_BEGIN  = 34;
  localparam int unsigned VDAT_END    = 514;
  localparam int unsigned LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } rx_state_e;

endpackage

// File: rtl/vga_sync_rx_if.sv
// VGA receive link: incoming sync/colour stream and recovered pixel/status outputs.
interface vga_sync_rx_if #(
  parameter int unsigned Cw = vga_timing_pkg::CW
);

  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic [2:0]    disp_RGB;
  logic          locked;
  logic          pix_valid;
  logic [Cw-1:0] pix_x;
  logic [Cw-1:0] pix_y;
  logic [2:0]    pix_rgb;
  logic          frame_start;
  logic          line_err;
  logic          frame_err;

  modport master (
    output pix_en, hsync, vsync, disp_RGB,
    input  locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, line_err, frame_err
  );

  modport slave (
    input  pix_en, hsync, vsync, disp_RGB,
    output locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, line_err, frame_err
  );

endinterface

// File: rtl/vga_rx_axis_cnt.sv
// One axis of position recovery: saturating counter restarted by a sync edge,
// flagging periods shorter or longer than Total.
module vga_rx_axis_cnt #(
  parameter int unsigned Cw    = 10,
  parameter int unsigned Total = 800
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance_i,
  input  logic          restart_i,
  output logic [Cw-1:0] pos_next_o,
  output logic          short_err_o,
  output logic          long_err_o
);

  localparam logic [Cw-1:0] Last = Cw'(Total - 1);
  localparam logic [Cw-1:0] Max  = '1;

  logic [Cw-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (advance_i) begin
      if (restart_i) begin
        pos_d = '0;
      end else if (pos_q != Max) begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  assign pos_next_o  = pos_d;
  assign short_err_o = advance_i & restart_i & (pos_q != Last);
  // Reaching the last position without the restart edge means the period overran.
  assign long_err_o  = advance_i & ~restart_i & (pos_q == Last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA stream receiver: recovers h/v position, checks frame timing, locks after
// consecutive good frames and emits active-area pixels with coordinates.
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned Cw         = CW,
  parameter int unsigned HTotal     = H_TOTAL,
  parameter int unsigned VTotal     = V_TOTAL,
  parameter int unsigned HDatBegin  = HDAT_BEGIN,
  parameter int unsigned HDatEnd    = HDAT_END,
  parameter int unsigned VDatBegin  = VDAT_BEGIN,
  parameter int unsigned VDatEnd    = VDAT_END,
  parameter int unsigned LockFrames = LOCK_FRAMES
) (
  input  logic         clock,
  input  logic         reset,
  vga_sync_rx_if.slave rx
);

  localparam logic [Cw-1:0] HBeg = Cw'(HDatBegin);
  localparam logic [Cw-1:0] HEnd = Cw'(HDatEnd);
  localparam logic [Cw-1:0] VBeg = Cw'(VDatBegin);
  localparam logic [Cw-1:0] VEnd = Cw'(VDatEnd);
  localparam int unsigned   GoodW = $clog2(LockFrames + 1);
  localparam logic [GoodW-1:0] GoodTarget = GoodW'(LockFrames);

  rx_state_e        state_q;
  logic [GoodW-1:0] good_q, good_inc;
  logic             hs_prev_q, vs_prev_q;
  logic             locked_q, pix_valid_q, frame_start_q, line_err_q, frame_err_q;
  logic [Cw-1:0]    pix_x_q, pix_y_q;
  logic [2:0]       pix_rgb_q;

  logic          line_start, frame_start_ev;
  logic [Cw-1:0] h_next, v_next;
  logic          h_short, h_long, v_short, v_long;
  logic          checking, line_err_c, frame_err_c, any_err, in_window;

  assign line_start     = rx.pix_en & hs_prev_q & ~rx.hsync;
  assign frame_start_ev = line_start & vs_prev_q & ~rx.vsync;

  vga_rx_axis_cnt #(
    .Cw   (Cw),
    .Total(HTotal)
  ) u_h_cnt (
    .clock      (clock),
    .reset      (reset),
    .advance_i  (rx.pix_en),
    .restart_i  (line_start),
    .pos_next_o (h_next),
    .short_err_o(h_short),
    .long_err_o (h_long)
  );

  vga_rx_axis_cnt #(
    .Cw   (Cw),
    .Total(VTotal)
  ) u_v_cnt (
    .clock      (clock),
    .reset      (reset),
    .advance_i  (line_start),
    .restart_i  (frame_start_ev),
    .pos_next_o (v_next),
    .short_err_o(v_short),
    .long_err_o (v_long)
  );

  assign checking    = (state_q != StSearch);
  assign line_err_c  = checking & (h_short | h_long);
  assign frame_err_c = checking & (v_short | v_long);
  assign any_err     = line_err_c | frame_err_c;
  assign good_inc    = good_q + 1'b1;
  assign in_window   = (h_next >= HBeg) && (h_next < HEnd) && (v_next >= VBeg) && (v_next < VEnd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StSearch;
      good_q        <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      if (rx.pix_en) begin
        hs_prev_q   <= rx.hsync;
        vs_prev_q   <= rx.vsync;
        line_err_q  <= line_err_c;
        frame_err_q <= frame_err_c;
        // Window bounds guarantee the subtractions below never wrap.
        if (state_q == StLocked && !any_err && in_window) begin
          pix_valid_q <= 1'b1;
          pix_x_q     <= h_next - HBeg;
          pix_y_q     <= v_next - VBeg;
          pix_rgb_q   <= rx.disp_RGB;
        end
        unique case (state_q)
          StSearch: begin
            if (frame_start_ev) begin
              state_q <= StVerify;
              good_q  <= '0;
            end
          end
          StVerify: begin
            if (any_err) begin
              state_q <= StSearch;
            end else if (frame_start_ev) begin
              good_q <= good_inc;
              if (good_inc == GoodTarget) begin
                state_q       <= StLocked;
                locked_q      <= 1'b1;
                frame_start_q <= 1'b1;
              end
            end
          end
          StLocked: begin
            if (any_err) begin
              state_q  <= StSearch;
              locked_q <= 1'b0;
            end else if (frame_start_ev) begin
              frame_start_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.locked      = locked_q;
  assign rx.pix_valid   = pix_valid_q;
  assign rx.pix_x       = pix_x_q;
  assign rx.pix_y       = pix_y_q;
  assign rx.pix_rgb     = pix_rgb_q;
  assign rx.frame_start = frame_start_q;
  assign rx.line_err    = line_err_q;
  assign rx.frame_err   = frame_err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a scaled-down 20x12 frame so that several
// whole frames fit in a short run.
module tb_vga_sync_rx;

  localparam int Cw  = 10;
  localparam int HT  = 20;
  localparam int VT  = 12;
  localparam int HB  = 5;
  localparam int HE  = 13;
  localparam int VB  = 3;
  localparam int VE  = 9;
  localparam int HSE = 3;
  localparam int VSE = 2;
  localparam int F   = HT * VT;

  logic clock = 1'b0;
  logic reset;
  bit   clk_run = 1'b1;

  vga_sync_rx_if #(.Cw(Cw)) bus ();

  vga_sync_rx #(
    .Cw        (Cw),
    .HTotal    (HT),
    .VTotal    (VT),
    .HDatBegin (HB),
    .HDatEnd   (HE),
    .VDatBegin (VB),
    .VDatEnd   (VE),
    .LockFrames(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx   (bus)
  );

  initial forever begin
    #5;
    if (clk_run) clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int sh, sv;
  bit hs_glitch, vs_supp;
  int n_valid, n_fs, n_lerr, n_ferr, pix_mis, off_pulse;
  int first_x, first_y, first_sh, first_sv, last_x, last_y;
  logic last_valid, last_fs, last_lerr, last_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_fs = 0; n_lerr = 0; n_ferr = 0; pix_mis = 0;
    first_x = -1; first_y = -1; first_sh = -1; first_sv = -1; last_x = -1; last_y = -1;
  endtask

  // One stream position: pix_en high for one clock, then low for one clock.
  task automatic sample();
    bus.pix_en   = 1'b1;
    bus.hsync    = hs_glitch ? 1'b0 : (sh >= HSE);
    bus.vsync    = vs_supp ? 1'b1 : (sv >= VSE);
    bus.disp_RGB = 3'(sh + sv);
    @(posedge clock); #1;
    last_valid = bus.pix_valid;
    last_fs    = bus.frame_start;
    last_lerr  = bus.line_err;
    last_ferr  = bus.frame_err;
    if (bus.pix_valid) begin
      n_valid++;
      if (n_valid == 1) begin
        first_x = int'(bus.pix_x); first_y = int'(bus.pix_y); first_sh = sh; first_sv = sv;
      end
      last_x = int'(bus.pix_x);
      last_y = int'(bus.pix_y);
      if (sh < HB || sh >= HE || sv < VB || sv >= VE || bus.pix_x !== Cw'(sh - HB) ||
          bus.pix_y !== Cw'(sv - VB) || bus.pix_rgb !== 3'(sh + sv)) pix_mis++;
    end
    if (bus.frame_start) n_fs++;
    if (bus.line_err) n_lerr++;
    if (bus.frame_err) n_ferr++;
    bus.pix_en = 1'b0;
    @(posedge clock); #1;
    if (bus.pix_valid | bus.frame_start | bus.line_err | bus.frame_err) off_pulse++;
    sh++;
    if (sh == HT) begin
      sh = 0;
      sv = (sv + 1) % VT;
    end
  endtask

  task automatic run(input int n);
    repeat (n) sample();
  endtask

  initial begin
    reset = 1'b1;
    bus.pix_en = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.disp_RGB = 3'd0;
    hs_glitch = 1'b0; vs_supp = 1'b0; off_pulse = 0;
    sh = 0; sv = 6;
    clear_stats();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_valid", 32'(bus.pix_valid), 0);
    chk("rst_x", 32'(bus.pix_x), 0);
    chk("rst_y", 32'(bus.pix_y), 0);
    chk("rst_rgb", 32'(bus.pix_rgb), 0);
    chk("rst_fs", 32'(bus.frame_start), 0);
    chk("rst_lerr", 32'(bus.line_err), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    reset = 1'b0;

    // Acquire lock from mid-frame: VERIFY at 1st frame start, LOCKED at 3rd.
    run(F - 6 * HT);
    chk("search_unlocked", 32'(bus.locked), 0);
    sample();
    run(F - 1);
    sample();
    run(F - 1);
    chk("lock_not_before_3rd", 32'(bus.locked), 0);
    sample();
    chk("locked_at_3rd", 32'(bus.locked), 1);
    chk("fs_pulse_at_lock", 32'(last_fs), 1);
    chk("fs_count_acquire", n_fs, 1);
    chk("lerr_acquire", n_lerr, 0);
    chk("ferr_acquire", n_ferr, 0);
    chk("no_pix_before_lock", n_valid, 0);

    // One full locked frame.
    clear_stats();
    run(F - 1);
    sample();
    chk("frame_pixels", n_valid, (HE - HB) * (VE - VB));
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("first_at_h", first_sh, HB);
    chk("first_at_v", first_sv, VB);
    chk("last_x", last_x, HE - HB - 1);
    chk("last_y", last_y, VE - VB - 1);
    chk("pix_content", pix_mis, 0);
    chk("fs_next_frame", 32'(last_fs), 1);
    chk("fs_count_frame", n_fs, 1);

    // Early hsync fall on line 5 at h=15.
    clear_stats();
    run(5 * HT + 15 - 1);
    hs_glitch = 1'b1;
    sample();
    hs_glitch = 1'b0;
    chk("short_line_lerr", 32'(last_lerr), 1);
    chk("short_line_unlock", 32'(bus.locked), 0);
    chk("short_line_ferr", 32'(last_ferr), 0);
    chk("short_line_lerr_cnt", n_lerr, 1);
    run(F - (5 * HT + 16));
    clear_stats();
    run(2 * F);
    chk("relock_wait_h", 32'(bus.locked), 0);
    chk("relock_wait_h_pix", n_valid, 0);
    sample();
    chk("relock_h", 32'(bus.locked), 1);
    chk("relock_h_errs", n_lerr + n_ferr, 0);

    // Suppressed vsync: error at the line start after the last line.
    run(F - 1);
    clear_stats();
    vs_supp = 1'b1;
    sample();
    chk("missing_vs_ferr", 32'(last_ferr), 1);
    chk("missing_vs_lerr", 32'(last_lerr), 0);
    chk("missing_vs_unlock", 32'(bus.locked), 0);
    chk("missing_vs_no_fs", 32'(last_fs), 0);
    run(F - 1);
    vs_supp = 1'b0;
    run(2 * F);
    chk("relock_wait_v", 32'(bus.locked), 0);
    chk("relock_wait_v_pix", n_valid, 0);
    sample();
    chk("relock_v", 32'(bus.locked), 1);
    chk("relock_v_ferr_cnt", n_ferr, 1);
    chk("relock_v_lerr_cnt", n_lerr, 0);

    // pix_en held low mid-line with the stream paused.
    clear_stats();
    run(4 * HT + 8 - 1);
    chk("pre_pause_x", last_x, 2);
    chk("pre_pause_y", last_y, 1);
    bus.pix_en = 1'b0;
    repeat (100) begin
      @(posedge clock); #1;
      if (bus.pix_valid | bus.frame_start | bus.line_err | bus.frame_err) off_pulse++;
    end
    chk("pause_held_x", 32'(bus.pix_x), 2);
    sample();
    chk("resume_valid", 32'(last_valid), 1);
    chk("resume_x", last_x, 3);
    chk("resume_y", last_y, 1);
    chk("resume_locked", 32'(bus.locked), 1);
    chk("pause_errs", n_lerr + n_ferr, 0);

    // Asynchronous reset with the clock stopped.
    clk_run = 1'b0;
    #20;
    reset = 1'b1;
    #1;
    chk("async_rst_locked", 32'(bus.locked), 0);
    chk("async_rst_x", 32'(bus.pix_x), 0);
    chk("async_rst_y", 32'(bus.pix_y), 0);
    chk("async_rst_rgb", 32'(bus.pix_rgb), 0);
    #20;
    reset = 1'b0;
    #3;
    clk_run = 1'b1;
    clear_stats();
    run(F - (4 * HT + 9));
    run(2 * F);
    chk("post_rst_unlocked", 32'(bus.locked), 0);
    chk("post_rst_no_pix", n_valid, 0);
    sample();
    chk("post_rst_relock", 32'(bus.locked), 1);
    chk("post_rst_errs", n_lerr + n_ferr, 0);
    chk("idle_clock_pulses", off_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
